vel_frame_tx: RTL and testbench



---
 rtl/vel_frame_tx_if.sv | 23 ++
 rtl/vel_frame_tx.sv | 119 +++++++++++
 tb/tb_vel_frame_tx.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vel_frame_tx_if.sv
// vel_frame_tx_if: sample input, byte stream output and status for vel_frame_tx.
// slave = framer side, master = producer/sink side.
interface vel_frame_tx_if #(
  parameter int FIFO_DEPTH = 8
);
  logic [15:0]                   vel_in;
  logic                          vel_valid;
  logic [7:0]                    tx_data;
  logic                          tx_valid;
  logic                          tx_ready;
  logic                          overflow;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;

  modport slave (
    input  vel_in, vel_valid, tx_ready,
    output tx_data, tx_valid, overflow, fifo_level
  );

  modport master (
    output vel_in, vel_valid, tx_ready,
    input  tx_data, tx_valid, overflow, fifo_level
  );
endinterface

// File: rtl/vel_frame_tx.sv
// vel_frame_tx: buffers signed 16-bit velocity samples in a FIFO and emits
// each one as a byte frame SYNC, SEQ, HI, LO [, CHK] on a valid/ready stream.
// Define VEL_FRAME_CHECKSUM_EN to append CHK = SEQ ^ HI ^ LO (5-byte frames).
module vel_frame_tx #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic           clk,
  input  logic           rst,
  vel_frame_tx_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_SEQ, S_HI, S_LO
`ifdef VEL_FRAME_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t      r_state, w_next;
  logic [15:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic [15:0] r_vel;
  logic [7:0]  r_seq;
  logic        r_ovf;

  logic        w_empty, w_full, w_pop, w_push, w_last;
  logic [7:0]  w_data;

  // Extra pointer bit separates full from empty when the indices match.
  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign w_push  = bus.vel_valid && (!w_full || w_pop);

  assign bus.tx_valid   = (r_state != S_IDLE);
  assign bus.tx_data    = w_data;
  assign bus.overflow   = r_ovf;
  assign bus.fifo_level = r_wr - r_rd;

  // Next state, pop request and byte mux; tx_ready only gates advancing.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_last = 1'b0;
    w_data = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_SYNC;
        end
      end
      S_SYNC: begin
        w_data = SYNC_BYTE;
        if (bus.tx_ready) w_next = S_SEQ;
      end
      S_SEQ: begin
        w_data = r_seq;
        if (bus.tx_ready) w_next = S_HI;
      end
      S_HI: begin
        w_data = r_vel[15:8];
        if (bus.tx_ready) w_next = S_LO;
      end
      S_LO: begin
        w_data = r_vel[7:0];
`ifdef VEL_FRAME_CHECKSUM_EN
        if (bus.tx_ready) w_next = S_CHK;
`else
        if (bus.tx_ready) w_last = 1'b1;
`endif
      end
`ifdef VEL_FRAME_CHECKSUM_EN
      S_CHK: begin
        w_data = r_seq ^ r_vel[15:8] ^ r_vel[7:0];
        if (bus.tx_ready) w_last = 1'b1;
      end
`endif
      default: w_next = S_IDLE;
    endcase
    // End of frame: chain straight into the next queued sample, no bubble.
    if (w_last) begin
      if (!w_empty) begin
        w_pop  = 1'b1;
        w_next = S_SYNC;
      end else begin
        w_next = S_IDLE;
      end
    end
  end

  // Sample storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= bus.vel_in;
  end

  // FSM state, FIFO pointers, frame register, sequence counter, sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wr    <= '0;
      r_rd    <= '0;
      r_vel   <= '0;
      r_seq   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) begin
        r_rd  <= r_rd + 1'b1;
        r_vel <= r_mem[r_rd[AW-1:0]];
      end
      if (w_last) r_seq <= r_seq + 8'd1;
      if (bus.vel_valid && !w_push) r_ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vel_frame_tx.sv
// tb_vel_frame_tx: scoreboard bench; expected frame bytes are queued when a
// sample is driven, accepted bytes are captured by a monitor and compared.
module tb_vel_frame_tx;
  localparam int DEPTH = 8;
`ifdef VEL_FRAME_CHECKSUM_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vel_frame_tx_if #(.FIFO_DEPTH(DEPTH)) bus();

  vel_frame_tx #(.FIFO_DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q [$];
  logic [7:0] obs_q [$];
  logic [7:0] exp_seq = 8'd0;
  logic       gap_watch = 1'b0;
  int         gap_cnt = 0;

  // Capture every byte that will be accepted on the coming rising edge.
  always @(negedge clk) begin
    if (!rst && bus.tx_valid && bus.tx_ready) obs_q.push_back(bus.tx_data);
    if (gap_watch && !bus.tx_valid) gap_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_sample(input logic [15:0] v, input bit keep);
    bus.vel_in = v;
    bus.vel_valid = 1'b1;
    if (keep) begin
      exp_q.push_back(8'hA5);
      exp_q.push_back(exp_seq);
      exp_q.push_back(v[15:8]);
      exp_q.push_back(v[7:0]);
`ifdef VEL_FRAME_CHECKSUM_EN
      exp_q.push_back(exp_seq ^ v[15:8] ^ v[7:0]);
`endif
      exp_seq = exp_seq + 8'd1;
    end
    tick(1);
    bus.vel_valid = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (obs_q.size() >= exp_q.size() && !bus.tx_valid) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    exp_seq = 8'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.vel_in = 16'h0000;
    bus.vel_valid = 1'b0;
    bus.tx_ready = 1'b0;
    #1;
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL reset tx_valid got %b want 0", bus.tx_valid); end
    total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL reset tx_data got %h want 00", bus.tx_data); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset overflow got %b want 0", bus.overflow); end
    total++; if (bus.fifo_level !== 4'd0) begin bad++; $display("FAIL reset fifo_level got %0d want 0", bus.fifo_level); end
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_single();
    logic [7:0] e, o;
    bit ok;
    bus.tx_ready = 1'b1;
    push_sample(16'h1234, 1'b1);
    total++; if (bus.fifo_level !== 4'd1) begin bad++; $display("FAIL latency level@E got %0d want 1", bus.fifo_level); end
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL latency valid@E got %b want 0", bus.tx_valid); end
    tick(1);
    total++; if (bus.fifo_level !== 4'd0) begin bad++; $display("FAIL latency level@E+1 got %0d want 0", bus.fifo_level); end
    total++; if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'hA5}) begin bad++; $display("FAIL latency sync@E+1 got %b/%h want 1/a5", bus.tx_valid, bus.tx_data); end
    wait_done(40, ok);
    total++; if (!ok) begin bad++; $display("FAIL single timeout got obs=%0d want exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL single byte got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL single byte got %h want %h", o, e); end end
    end
    total++; if (obs_q.size() != 0 || bus.tx_valid !== 1'b0) begin bad++; $display("FAIL single tail got extra=%0d valid=%b want 0/0", obs_q.size(), bus.tx_valid); end
    obs_q.delete();
  endtask

  task automatic test_negative();
    logic [7:0] e, o;
    bit ok;
    push_sample(16'hFFFE, 1'b1);
    wait_done(40, ok);
    total++; if (!ok) begin bad++; $display("FAIL negative timeout got obs=%0d want exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL negative byte got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL negative byte got %h want %h", o, e); end end
    end
    obs_q.delete();
  endtask

  task automatic test_backpressure();
    logic [7:0] e, o;
    bit ok;
    push_sample(16'h1234, 1'b1);
    tick(3);
    total++; if (bus.tx_data !== 8'h12) begin bad++; $display("FAIL bp in HI got %h want 12", bus.tx_data); end
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      total++; if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'h12}) begin bad++; $display("FAIL bp stall%0d got %b/%h want 1/12", i, bus.tx_valid, bus.tx_data); end
    end
    bus.tx_ready = 1'b1;
    wait_done(40, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp timeout got obs=%0d want exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL bp byte got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL bp byte got %h want %h", o, e); end end
    end
    obs_q.delete();
  endtask

  task automatic test_overflow();
    logic [7:0] e, o;
    bit ok;
    do_reset();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_sample(16'(i), i < 9);
    total++; if (bus.fifo_level !== 4'd8) begin bad++; $display("FAIL ovf level got %0d want 8", bus.fifo_level); end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf flag got %b want 1", bus.overflow); end
    tick(3);
    total++; if ({bus.overflow, bus.fifo_level, bus.tx_data} !== {1'b1, 4'd8, 8'hA5}) begin bad++; $display("FAIL ovf stall got %b/%0d/%h want 1/8/a5", bus.overflow, bus.fifo_level, bus.tx_data); end
    bus.tx_ready = 1'b1;
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovf timeout got obs=%0d want exp=%0d", obs_q.size(), exp_q.size()); end
    total++; if (obs_q.size() != 9 * FL) begin bad++; $display("FAIL ovf bytes got %0d want %0d", obs_q.size(), 9 * FL); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL ovf byte got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL ovf byte got %h want %h", o, e); end end
    end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf sticky got %b want 1", bus.overflow); end
    obs_q.delete();
  endtask

  task automatic test_seq_wrap();
    logic [7:0] e, o;
    bit ok;
    int g0;
    do_reset();
    bus.tx_ready = 1'b1;
    g0 = gap_cnt;
    for (int i = 0; i < 257; i++) begin
      push_sample(16'(i * 37 + 16'h8001), 1'b1);
      if (i == 1) gap_watch = 1'b1;
      if (i >= 2) tick(FL - 1);
    end
    wait_done(FL * 20, ok);
    gap_watch = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL wrap timeout got obs=%0d want exp=%0d", obs_q.size(), exp_q.size()); end
    total++; if (gap_cnt - g0 != 0) begin bad++; $display("FAIL wrap gaps got %0d want 0", gap_cnt - g0); end
    if (obs_q.size() > 256 * FL + 1) begin
      total++; if (obs_q[255 * FL + 1] !== 8'hFF) begin bad++; $display("FAIL wrap seq255 got %h want ff", obs_q[255 * FL + 1]); end
      total++; if (obs_q[256 * FL + 1] !== 8'h00) begin bad++; $display("FAIL wrap seq256 got %h want 00", obs_q[256 * FL + 1]); end
    end else begin
      total++; bad++; $display("FAIL wrap bytes got %0d want %0d", obs_q.size(), 257 * FL);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL wrap byte got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL wrap byte got %h want %h", o, e); end end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [7:0] e, o;
    bit ok;
    do_reset();
    bus.tx_ready = 1'b1;
    push_sample(16'h0A0B, 1'b0);
    push_sample(16'h1111, 1'b0);
    push_sample(16'h2222, 1'b0);
    push_sample(16'h3333, 1'b0);
    tick(1);
    total++; if ({bus.tx_data, bus.fifo_level} !== {8'h0B, 4'd3}) begin bad++; $display("FAIL rstmid pre got %h/%0d want 0b/3", bus.tx_data, bus.fifo_level); end
    rst = 1'b1;
    #1;
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL rstmid valid got %b want 0", bus.tx_valid); end
    total++; if (bus.fifo_level !== 4'd0) begin bad++; $display("FAIL rstmid level got %0d want 0", bus.fifo_level); end
    tick(1);
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    exp_seq = 8'd0;
    push_sample(16'hBEEF, 1'b1);
    wait_done(40, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid timeout got obs=%0d want exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL rstmid byte got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL rstmid byte got %h want %h", o, e); end end
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_negative();
    test_backpressure();
    test_overflow();
    test_seq_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
